// File: rtl/psum_write_responder.sv
// Psum scratchpad responder: serves registered reads, commits (optionally accumulated)
// writes, pushes each result into a 4-entry output FIFO and replies on the stall code.
module psum_write_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chip_en,
  input  logic                  global_rst,
  input  logic                  psum_mode,
  input  logic                  psum_buffer_ren,
  input  logic                  next_psum_raddr,
  input  logic                  next_psum_waddr,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  can_read_psum,
  output logic                  psum_buffer_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            stall,
  output logic                  psum_co,
  output logic                  error,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WRITE,
    W_ACK,
    W_DONE
  } wstate_e;

  wstate_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]  snap_q, snap_d;
  logic [ADDR_WIDTH:0]    wcount_q, wcount_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic [1:0]             fifo_wr_q, fifo_wr_d;
  logic [1:0]             fifo_rd_q, fifo_rd_d;
  logic [2:0]             fifo_cnt_q, fifo_cnt_d;

  logic [DATA_WIDTH-1:0]  mem      [DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

  logic pop, fifo_full, commit, snap_last;

  assign can_read_psum     = {1'b0, raddr_q} < wcount_q;
  assign snap_last         = snap_q == {ADDR_WIDTH{1'b1}};
  assign psum_co           = waddr_q == {ADDR_WIDTH{1'b1}};
  assign out_valid         = fifo_cnt_q != 3'd0;
  assign out_data          = fifo_mem[fifo_rd_q];
  assign pop               = out_valid & out_ready;
  // A pop in the same cycle frees the slot the commit needs.
  assign fifo_full         = (fifo_cnt_q == 3'(FIFO_DEPTH)) & ~pop;
  assign commit            = chip_en & ~global_rst & (state_q == W_WRITE) & ~fifo_full;
  assign rdata             = rdata_q;
  assign psum_buffer_valid = valid_q;
  assign error             = error_q;

  always_comb begin
    unique case (state_q)
      W_ACK:   stall = snap_last ? 2'b11 : 2'b10;
      W_DONE:  stall = 2'b11;
      default: stall = 2'b00;
    endcase
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block infers a latch.
    state_d    = state_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    snap_d     = snap_q;
    wcount_d   = wcount_q;
    rdata_d    = rdata_q;
    sum_d      = sum_q;
    valid_d    = valid_q;
    error_d    = error_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;

    if (global_rst) begin
      state_d    = W_IDLE;
      raddr_d    = '0;
      waddr_d    = '0;
      snap_d     = '0;
      wcount_d   = '0;
      rdata_d    = '0;
      sum_d      = '0;
      valid_d    = 1'b0;
      error_d    = 1'b0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
    end else begin
      // The consumer side of the FIFO keeps draining even while chip_en is low.
      if (pop)    fifo_rd_d = fifo_rd_q + 2'd1;
      if (commit) fifo_wr_d = fifo_wr_q + 2'd1;
      case ({commit, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase

      if (chip_en) begin
        unique case (state_q)
          W_IDLE: begin
            if (wr_req) begin
              sum_d   = wr_data + ((psum_mode && valid_q) ? rdata_q : '0);
              snap_d  = waddr_q;
              state_d = W_WRITE;
            end
          end
          W_WRITE: begin
            if (wr_req || next_psum_waddr) error_d = 1'b1;
            if (!fifo_full) begin
              if ({1'b0, snap_q} >= wcount_q) wcount_d = {1'b0, snap_q} + (ADDR_WIDTH+1)'(1);
              valid_d = 1'b0;
              state_d = W_ACK;
            end
          end
          W_ACK: begin
            if (wr_req) error_d = 1'b1;
            state_d = snap_last ? W_DONE : W_IDLE;
          end
          default: state_d = W_DONE;
        endcase

        if (next_psum_raddr) begin
          raddr_d = raddr_q + ADDR_WIDTH'(1);
          valid_d = 1'b0;
        end
        // A read issued alongside a commit or raddr step wins and re-arms valid.
        if (psum_buffer_ren && can_read_psum) begin
          rdata_d = mem[raddr_q];
          valid_d = 1'b1;
        end
        if (next_psum_waddr) waddr_d = waddr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= W_IDLE;
      raddr_q    <= '0;
      waddr_q    <= '0;
      snap_q     <= '0;
      wcount_q   <= '0;
      rdata_q    <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      snap_q     <= snap_d;
      wcount_q   <= wcount_d;
      rdata_q    <= rdata_d;
      sum_q      <= sum_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: storage arrays carry no reset; occupancy and wcount decide what is meaningful.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[snap_q]         <= sum_q;
      fifo_mem[fifo_wr_q] <= sum_q;
    end
  end

endmodule

// File: tb/tb_psum_write_responder.sv
// Randomized and directed bench for psum_write_responder, checked every cycle
// against a transaction-level reference model.
module tb_psum_write_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, chip_en, global_rst, psum_mode;
  logic        psum_buffer_ren, next_psum_raddr, next_psum_waddr, wr_req, out_ready;
  logic [15:0] wr_data;
  logic        can_read_psum, psum_buffer_valid, psum_co, error, out_valid;
  logic [15:0] rdata, out_data;
  logic [1:0]  stall;

  int n_checks = 0;
  int n_fail   = 0;

  psum_write_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .chip_en           (chip_en),
    .global_rst        (global_rst),
    .psum_mode         (psum_mode),
    .psum_buffer_ren   (psum_buffer_ren),
    .next_psum_raddr   (next_psum_raddr),
    .next_psum_waddr   (next_psum_waddr),
    .wr_req            (wr_req),
    .wr_data           (wr_data),
    .can_read_psum     (can_read_psum),
    .psum_buffer_valid (psum_buffer_valid),
    .rdata             (rdata),
    .stall             (stall),
    .psum_co           (psum_co),
    .error             (error),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: scratchpad, pointers, one pending transaction and the output queue.
  int          m_raddr, m_waddr, m_wcount, m_snap;
  logic [15:0] m_mem [DEPTH];
  bit          m_mknown [DEPTH];
  logic [15:0] m_rdata, m_sum;
  bit          m_rknown, m_valid, m_err, m_pend, m_ack, m_done;
  logic [15:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_raddr = 0; m_waddr = 0; m_wcount = 0; m_snap = 0;
    m_rdata = '0; m_rknown = 1'b1; m_sum = '0;
    m_valid = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_ack = 1'b0; m_done = 1'b0;
    m_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          pop, commit, can;
    logic [15:0] rd;
    bit          rk;
    if (global_rst) begin
      model_clear();
      return;
    end
    pop = (m_q.size() > 0) && out_ready;
    if (!chip_en) begin
      if (pop) void'(m_q.pop_front());
      return;
    end
    commit = m_pend && !(m_q.size() == 4 && !pop);
    can    = m_raddr < m_wcount;
    rd     = m_mem[m_raddr];
    rk     = m_mknown[m_raddr];

    if (wr_req && (m_pend || m_ack)) m_err = 1'b1;
    if (next_psum_waddr && m_pend)   m_err = 1'b1;

    if (commit) begin
      m_mem[m_snap]    = m_sum;
      m_mknown[m_snap] = 1'b1;
      if (m_snap >= m_wcount) m_wcount = m_snap + 1;
      m_valid = 1'b0;
      m_pend  = 1'b0;
      m_ack   = 1'b1;
    end else if (m_ack) begin
      m_ack = 1'b0;
      if (m_snap == DEPTH - 1) m_done = 1'b1;
    end else if (!m_pend && !m_done && wr_req) begin
      m_sum  = wr_data + ((psum_mode && m_valid) ? m_rdata : 16'h0);
      m_snap = m_waddr;
      m_pend = 1'b1;
    end

    if (next_psum_raddr) m_valid = 1'b0;
    if (psum_buffer_ren && can) begin
      m_rdata  = rd;
      m_rknown = rk;
      m_valid  = 1'b1;
    end
    if (next_psum_raddr) m_raddr = (m_raddr + 1) % DEPTH;
    if (next_psum_waddr) m_waddr = (m_waddr + 1) % DEPTH;

    if (pop) void'(m_q.pop_front());
    if (commit) m_q.push_back(m_sum);
  endtask

  task automatic compare_all();
    logic [1:0] exp_stall;
    exp_stall = m_done ? 2'b11 : (m_ack ? ((m_snap == DEPTH - 1) ? 2'b11 : 2'b10) : 2'b00);
    check("stall", 32'(stall), 32'(exp_stall));
    check("can_read", 32'(can_read_psum), 32'(m_raddr < m_wcount));
    check("valid", 32'(psum_buffer_valid), 32'(m_valid));
    if (m_rknown) check("rdata", 32'(rdata), 32'(m_rdata));
    check("psum_co", 32'(psum_co), 32'(m_waddr == DEPTH - 1));
    check("error", 32'(error), 32'(m_err));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
  endtask

  // One clock: model and DUT see the same inputs, outputs compared 1 time unit after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    wr_req = 1'b0; psum_buffer_ren = 1'b0; next_psum_raddr = 1'b0;
    next_psum_waddr = 1'b0; global_rst = 1'b0;
  endtask

  task automatic pulse_waddr(input int n);
    for (int i = 0; i < n; i++) begin
      next_psum_waddr = 1'b1;
      step();
    end
  endtask

  // Issue a write, wait (bounded) for the reply cycle, then step past it.
  task automatic write_op(input logic [15:0] d, input bit mode);
    int n = 0;
    wr_data = d; psum_mode = mode; wr_req = 1'b1;
    step();
    while (stall == 2'b00 && n < 8) begin
      step();
      n++;
    end
    if (n == 8) check("write_timeout", 32'(stall), 32'h2);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mknown[i] = 1'b0;
    reset = 1'b1; chip_en = 1'b1; global_rst = 1'b0; psum_mode = 1'b0;
    psum_buffer_ren = 1'b0; next_psum_raddr = 1'b0; next_psum_waddr = 1'b0;
    wr_req = 1'b0; wr_data = '0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare_all();
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_co", 32'(psum_co), 32'h0);

    // Store 5 at waddr 2; reply arrives two cycles after the request.
    pulse_waddr(2);
    wr_data = 16'h0005; psum_mode = 1'b0; wr_req = 1'b1;
    step(); check("st_c1", 32'(stall), 32'h0);
    step(); check("st_ack", 32'(stall), 32'h2);
    step(); check("st_c3", 32'(stall), 32'h0);
    check("st_out", 32'(out_data), 32'h5);
    check("st_canrd", 32'(can_read_psum), 32'h1);

    // Accumulate 3 onto mem[2].
    next_psum_raddr = 1'b1; step();
    next_psum_raddr = 1'b1; step();
    psum_buffer_ren = 1'b1; step();
    check("acc_valid", 32'(psum_buffer_valid), 32'h1);
    check("acc_rdata", 32'(rdata), 32'h5);
    write_op(16'h0003, 1'b1);
    check("acc_vdrop", 32'(psum_buffer_valid), 32'h0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("acc_out", 32'(out_data), 32'h8);

    // Accumulate wrap-around and waddr wrap with carry-out.
    global_rst = 1'b1; step();
    write_op(16'hFFFF, 1'b0);
    psum_buffer_ren = 1'b1; step();
    check("wrap_rd", 32'(rdata), 32'hFFFF);
    write_op(16'h0002, 1'b1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("wrap_sum", 32'(out_data), 32'h1);
    psum_mode = 1'b0;
    pulse_waddr(15);
    check("co_high", 32'(psum_co), 32'h1);
    pulse_waddr(1);
    check("co_wrap", 32'(psum_co), 32'h0);

    // Fill every address; the last one is terminal and ignores further requests.
    global_rst = 1'b1; step();
    out_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      write_op(16'($urandom), 1'b0);
      if (a < DEPTH - 1) pulse_waddr(1);
    end
    repeat (3) step();
    wr_req = 1'b1; wr_data = 16'h1234; step();
    step();
    check("done_nopush", 32'(out_valid), 32'h0);
    check("done_stall", 32'(stall), 32'h3);
    global_rst = 1'b1; step();
    check("grst_stall", 32'(stall), 32'h0);
    check("grst_fifo", 32'(out_valid), 32'h0);

    // FIFO full: the fifth write waits until a pop frees a slot in the same cycle.
    out_ready = 1'b0;
    repeat (4) write_op(16'($urandom), 1'b0);
    wr_data = 16'hBEEF; wr_req = 1'b1;
    step(); check("full_c1", 32'(stall), 32'h0);
    step(); check("full_c2", 32'(stall), 32'h0);
    step(); check("full_c3", 32'(stall), 32'h0);
    out_ready = 1'b1;
    step(); check("full_ack", 32'(stall), 32'h2);
    check("full_keep", 32'(out_valid), 32'h1);
    repeat (6) step();

    // Randomized traffic, avoiding protocol violations.
    for (int i = 0; i < 800; i++) begin
      chip_en         = $urandom_range(99) < 90;
      out_ready       = 1'($urandom_range(1));
      psum_mode       = 1'($urandom_range(1));
      wr_data         = 16'($urandom);
      psum_buffer_ren = $urandom_range(99) < 30;
      next_psum_raddr = $urandom_range(99) < 15;
      next_psum_waddr = !m_pend && ($urandom_range(99) < 20);
      wr_req          = !m_pend && !m_ack && ($urandom_range(99) < 25);
      global_rst      = $urandom_range(99) < (m_done ? 10 : 1);
      step();
    end
    chip_en = 1'b1; out_ready = 1'b1;

    // Sticky protocol error: request during W_WRITE.
    global_rst = 1'b1; step();
    wr_data = 16'h0011; wr_req = 1'b1; step();
    wr_req = 1'b1; step();
    check("err_set", 32'(error), 32'h1);
    repeat (4) step();
    check("err_sticky", 32'(error), 32'h1);

    // Asynchronous reset in W_WRITE drops the pending write.
    out_ready = 1'b0;
    wr_data = 16'h0077; wr_req = 1'b1; step();
    #2 reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    check("ar_stall", 32'(stall), 32'h0);
    check("ar_err", 32'(error), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("ar_nopush", 32'(out_valid), 32'h0);
    check("ar_valid", 32'(psum_buffer_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
